misty1_host_if: RTL and testbench
=================================

Name: misty1_host_if

Overview:
- Upstream/downstream host adapter for the one-round/three-clock MISTY1 macro.
- Assembles a 128-bit key and a 64-bit block from 32-bit host writes, then issues the core's key_rdy/data_rdy strobes and en_de mode.
- Captures data_out on data_valid into a result register that the host reads back as 32-bit words.
- Sequences key load, then data processing, with a watchdog and error flag.

Parameters:
TIMEOUT, 255, maximum cycles spent in any wait state before abort (8-bit counter).

Ports:
clk  in  1  system clock, rising edge
nreset  in  1  synchronous active-low reset
wr_en  in  1  host write strobe
wr_addr  in  3  0..3 = key words (0 = key[127:96] .. 3 = key[31:0]); 4..5 = data words (4 = data[63:32]); 6..7 ignored
wr_data  in  32  host write data
cmd_valid  in  1  command request
cmd  in  2  0 = load key, 1 = encrypt, 2 = decrypt, 3 = reserved
cmd_ready  out  1  command accepted this cycle when cmd_valid&cmd_ready
rd_sel  in  1  0 = result[63:32], 1 = result[31:0]
rd_data  out  32  combinational read of result register
result_valid  out  1  result register holds a fresh result
key_loaded  out  1  core holds a schedule for the current key registers
err  out  1  sticky error; cleared by next accepted command
core_key_in  out  128  key register contents
core_data_in  out  64  data register contents
core_key_rdy  out  1  one-cycle key-schedule start
core_data_rdy  out  1  one-cycle block start
core_en_de  out  1  0 = encrypt, 1 = decrypt; held stable from DATA_REQ through DATA_WAIT
core_data_out  in  64  core result
core_data_valid  in  1  one-cycle pulse, result valid
core_key_valid  in  1  one-cycle pulse, key schedule complete
core_busy  in  1  core processing

Behaviour:
- Reset (nreset=0 at clk edge): state IDLE; key, data and result registers = 0; result_valid=0, key_loaded=0, err=0; core_key_rdy=0, core_data_rdy=0, core_en_de=0; watchdog=0. Reset mid-operation aborts immediately; the core must be reset by the same nreset.
- Writes are accepted only in IDLE; writes in other states are dropped.
  - A key-word write clears key_loaded the same edge.
  - A data-word write does not affect result_valid.
- cmd_ready = (state==IDLE) & ~core_busy.
- Accepted cmd clears err. cmd=3 sets err and stays in IDLE.
  - cmd=1/2 with key_loaded=0 sets err and stays in IDLE.
- FSM states: IDLE, KEY_REQ, KEY_WAIT, DATA_REQ, DATA_WAIT.
  - IDLE --cmd 0--> KEY_REQ.
  - IDLE --cmd 1/2, key_loaded--> DATA_REQ; latch core_en_de=cmd[1]; clear result_valid.
  - KEY_REQ: core_key_rdy=1 for exactly one cycle -> KEY_WAIT.
  - KEY_WAIT: on core_key_valid -> key_loaded=1 -> IDLE.
  - DATA_REQ: core_data_rdy=1 for exactly one cycle -> DATA_WAIT.
  - DATA_WAIT: on core_data_valid -> result<=core_data_out, result_valid=1 -> IDLE.
- Watchdog:
  - Resets on entry to KEY_WAIT/DATA_WAIT and increments each wait cycle.
  - When it reaches TIMEOUT without the expected pulse: err=1 -> IDLE; key_loaded=0 if aborting KEY_WAIT; result_valid stays 0.
- Latency: cmd accept edge -> core_key_rdy/core_data_rdy high the following cycle. Result visible on rd_data the cycle after the core_data_valid edge.
- A spurious core_data_valid/core_key_valid outside its wait state is ignored.
- Simultaneous wr_en and accepted cmd in IDLE: the write takes effect; the key/data used by the core is the post-write value because the core samples inputs at the rdy strobe a cycle later. A key write with cmd 1/2 in the same cycle is rejected (err), since key_loaded is evaluated pre-write.
- core_key_in/core_data_in are stable outside IDLE.

Test Plan:
- Reset → all outputs 0, cmd_ready=1. Write key 0011_2233_4455_6677_8899_aabb_ccdd_eeff, issue cmd 0 → single core_key_rdy pulse; key_loaded=1 after core_key_valid.
- Write data 0123_4567_89ab_cdef, cmd 1 with real MISTY1 core → core_en_de=0, one core_data_rdy pulse; result_valid=1; rd_sel 0/1 = 8b1da5f5 / 6ab3d07c.
- Write data 8b1d_a5f5_6ab3_d07c, cmd 2 → core_en_de=1; result = 0123_4567_89ab_cdef.
- After reset, cmd 1 without a key load → err=1, no core_data_rdy, state IDLE. Key-word write after a key load → key_loaded=0.
- Stub core that never asserts data_valid, TIMEOUT=16 → err=1 and IDLE exactly 16 cycles after entering DATA_WAIT. wr_en during the wait is ignored (data register unchanged).
- nreset=0 during DATA_WAIT → next cycle all outputs at reset values; cmd_ready=1 once core_busy=0.

Source files
------------

// File: rtl/misty1_host_if.sv
// Host adapter for the one-round MISTY1 macro: assembles key/data from 32-bit writes,
// sequences key schedule and block processing, and exposes the result as 32-bit reads.
module misty1_host_if #(
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         wr_en,
  input  logic [2:0]   wr_addr,
  input  logic [31:0]  wr_data,
  input  logic         cmd_valid,
  input  logic [1:0]   cmd,
  output logic         cmd_ready,
  input  logic         rd_sel,
  output logic [31:0]  rd_data,
  output logic         result_valid,
  output logic         key_loaded,
  output logic         err,
  output logic [127:0] core_key_in,
  output logic [63:0]  core_data_in,
  output logic         core_key_rdy,
  output logic         core_data_rdy,
  output logic         core_en_de,
  input  logic [63:0]  core_data_out,
  input  logic         core_data_valid,
  input  logic         core_key_valid,
  input  logic         core_busy
);

  // state     | meaning
  // IDLE      | accepts host writes and commands
  // KEY_REQ   | one-cycle core_key_rdy strobe
  // KEY_WAIT  | waiting for core_key_valid, watchdog running
  // DATA_REQ  | one-cycle core_data_rdy strobe, mode held
  // DATA_WAIT | waiting for core_data_valid, watchdog running
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    KEY_REQ   = 3'd1,
    KEY_WAIT  = 3'd2,
    DATA_REQ  = 3'd3,
    DATA_WAIT = 3'd4
  } state_t;

  // Abort fires on the TIMEOUT-th wait cycle; the counter holds cycles already spent.
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  state_t       state;
  state_t       state_next;
  logic [127:0] key_reg;
  logic [63:0]  data_reg;
  logic [63:0]  result_reg;
  logic [7:0]   wd;
  logic         mode_reg;

  logic accept;
  logic in_idle;
  logic key_wr;
  logic data_wr;
  logic wd_clr;
  logic wd_inc;
  logic set_err;
  logic clr_err;
  logic set_kl;
  logic clr_kl;
  logic latch_mode;
  logic clr_rv;
  logic capture;

  assign in_idle   = (state == IDLE);
  assign cmd_ready = in_idle & ~core_busy;
  assign accept    = cmd_valid & cmd_ready;
  assign key_wr    = wr_en & in_idle & ~wr_addr[2];
  assign data_wr   = wr_en & in_idle & (wr_addr[2:1] == 2'b10);

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next    = state;
    core_key_rdy  = 1'b0;
    core_data_rdy = 1'b0;
    wd_clr        = 1'b0;
    wd_inc        = 1'b0;
    set_err       = 1'b0;
    clr_err       = 1'b0;
    set_kl        = 1'b0;
    clr_kl        = 1'b0;
    latch_mode    = 1'b0;
    clr_rv        = 1'b0;
    capture       = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          clr_err = 1'b1;
          case (cmd)
            2'd0: state_next = KEY_REQ;
            2'd1, 2'd2: begin
              // key_loaded is the pre-write value, so a same-cycle key write does not help
              if (key_loaded) begin
                state_next = DATA_REQ;
                latch_mode = 1'b1;
                clr_rv     = 1'b1;
              end else begin
                set_err = 1'b1;
              end
            end
            default: set_err = 1'b1;
          endcase
        end
      end
      KEY_REQ: begin
        core_key_rdy = 1'b1;
        wd_clr       = 1'b1;
        state_next   = KEY_WAIT;
      end
      KEY_WAIT: begin
        if (core_key_valid) begin
          set_kl     = 1'b1;
          state_next = IDLE;
        end else if (wd == WD_LAST) begin
          set_err    = 1'b1;
          clr_kl     = 1'b1;
          state_next = IDLE;
        end else begin
          wd_inc = 1'b1;
        end
      end
      DATA_REQ: begin
        core_data_rdy = 1'b1;
        wd_clr        = 1'b1;
        state_next    = DATA_WAIT;
      end
      DATA_WAIT: begin
        if (core_data_valid) begin
          capture    = 1'b1;
          state_next = IDLE;
        end else if (wd == WD_LAST) begin
          set_err    = 1'b1;
          state_next = IDLE;
        end else begin
          wd_inc = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      key_reg  <= '0;
      data_reg <= '0;
    end else begin
      if (key_wr) begin
        case (wr_addr[1:0])
          2'd0:    key_reg[127:96] <= wr_data;
          2'd1:    key_reg[95:64]  <= wr_data;
          2'd2:    key_reg[63:32]  <= wr_data;
          default: key_reg[31:0]   <= wr_data;
        endcase
      end
      if (data_wr) begin
        if (wr_addr[0]) begin
          data_reg[31:0] <= wr_data;
        end else begin
          data_reg[63:32] <= wr_data;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      wd <= '0;
    end else if (wd_clr) begin
      wd <= '0;
    end else if (wd_inc) begin
      wd <= wd + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      result_reg   <= '0;
      result_valid <= 1'b0;
      key_loaded   <= 1'b0;
      err          <= 1'b0;
      mode_reg     <= 1'b0;
    end else begin
      if (capture) begin
        result_reg <= core_data_out;
      end
      if (capture) begin
        result_valid <= 1'b1;
      end else if (clr_rv) begin
        result_valid <= 1'b0;
      end
      if (set_kl) begin
        key_loaded <= 1'b1;
      end else if (clr_kl || key_wr) begin
        key_loaded <= 1'b0;
      end
      if (set_err) begin
        err <= 1'b1;
      end else if (clr_err) begin
        err <= 1'b0;
      end
      if (latch_mode) begin
        mode_reg <= cmd[1];
      end
    end
  end

  assign core_key_in  = key_reg;
  assign core_data_in = data_reg;
  assign core_en_de   = mode_reg;
  assign rd_data      = rd_sel ? result_reg[31:0] : result_reg[63:32];

endmodule

// File: tb/tb_misty1_host_if.sv
// Directed bench for misty1_host_if; the MISTY1 core is played by the bench itself
// returning the known test-vector ciphertext/plaintext.
module tb_misty1_host_if;

  logic         clk;
  logic         nreset;
  logic         wr_en;
  logic [2:0]   wr_addr;
  logic [31:0]  wr_data;
  logic         cmd_valid;
  logic [1:0]   cmd;
  logic         cmd_ready;
  logic         rd_sel;
  logic [31:0]  rd_data;
  logic         result_valid;
  logic         key_loaded;
  logic         err;
  logic [127:0] core_key_in;
  logic [63:0]  core_data_in;
  logic         core_key_rdy;
  logic         core_data_rdy;
  logic         core_en_de;
  logic [63:0]  core_data_out;
  logic         core_data_valid;
  logic         core_key_valid;
  logic         core_busy;

  int total = 0;
  int bad   = 0;
  int key_pulses  = 0;
  int data_pulses = 0;

  misty1_host_if #(.TIMEOUT(16)) dut (
    .clk(clk), .nreset(nreset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready),
    .rd_sel(rd_sel), .rd_data(rd_data),
    .result_valid(result_valid), .key_loaded(key_loaded), .err(err),
    .core_key_in(core_key_in), .core_data_in(core_data_in),
    .core_key_rdy(core_key_rdy), .core_data_rdy(core_data_rdy), .core_en_de(core_en_de),
    .core_data_out(core_data_out), .core_data_valid(core_data_valid),
    .core_key_valid(core_key_valid), .core_busy(core_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (core_key_rdy)  key_pulses++;
    if (core_data_rdy) data_pulses++;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic issue(input logic [1:0] c);
    cmd_valid = 1'b1; cmd = c;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic load_key(input logic [127:0] k);
    for (int i = 0; i < 4; i++) begin
      wr(3'(i), k[127 - 32*i -: 32]);
    end
  endtask

  task automatic finish_key();
    core_busy = 1'b1;
    tick(); tick();
    core_key_valid = 1'b1; core_busy = 1'b0;
    tick();
    core_key_valid = 1'b0;
  endtask

  task automatic finish_data(input logic [63:0] r);
    core_busy = 1'b1;
    tick(); tick(); tick();
    core_data_out = r; core_data_valid = 1'b1; core_busy = 1'b0;
    tick();
    core_data_valid = 1'b0;
  endtask

  task automatic do_reset();
    nreset = 1'b0;
    tick(); tick();
    nreset = 1'b1;
  endtask

  localparam logic [127:0] KEY = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [63:0]  PT  = 64'h01234567_89abcdef;
  localparam logic [63:0]  CT  = 64'h8b1da5f5_6ab3d07c;

  int kp0;
  int dp0;

  initial begin
    nreset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    cmd_valid = 1'b0; cmd = '0; rd_sel = 1'b0;
    core_data_out = '0; core_data_valid = 1'b0; core_key_valid = 1'b0; core_busy = 1'b0;
    do_reset();

    check("rst_state", {result_valid, key_loaded, err, core_key_rdy, core_data_rdy, core_en_de, cmd_ready},
          7'b0000001);
    check("rst_rd", rd_data, 0);
    check("rst_key", core_key_in, 0);
    check("rst_data", core_data_in, 0);

    // key load
    load_key(KEY);
    check("key_reg", core_key_in, KEY);
    kp0 = key_pulses;
    issue(2'd0);
    check("key_rdy_hi", {core_key_rdy, cmd_ready}, 2'b10);
    tick();
    check("key_rdy_lo", core_key_rdy, 0);
    finish_key();
    check("key_loaded", key_loaded, 1);
    check("key_pulses", key_pulses - kp0, 1);

    // encrypt
    wr(3'd4, PT[63:32]);
    wr(3'd5, PT[31:0]);
    check("data_reg", core_data_in, PT);
    dp0 = data_pulses;
    issue(2'd1);
    check("enc_req", {core_data_rdy, core_en_de, result_valid}, 3'b100);
    tick();
    check("enc_wait_mode", {core_data_rdy, core_en_de}, 2'b00);
    finish_data(CT);
    check("enc_rv", result_valid, 1);
    rd_sel = 1'b0; #1;
    check("enc_hi", rd_data, 32'h8b1da5f5);
    rd_sel = 1'b1; #1;
    check("enc_lo", rd_data, 32'h6ab3d07c);
    check("enc_pulses", data_pulses - dp0, 1);

    // decrypt
    wr(3'd4, CT[63:32]);
    wr(3'd5, CT[31:0]);
    check("dec_rv_kept", result_valid, 1);
    issue(2'd2);
    check("dec_req", {core_data_rdy, core_en_de, result_valid}, 3'b110);
    tick();
    check("dec_wait_mode", core_en_de, 1);
    finish_data(PT);
    rd_sel = 1'b0; #1;
    check("dec_hi", rd_data, 32'h01234567);
    rd_sel = 1'b1; #1;
    check("dec_lo", rd_data, 32'h89abcdef);

    // spurious valid in IDLE must not overwrite the result
    core_data_out = 64'hdeadbeef_00000000; core_data_valid = 1'b1;
    tick();
    core_data_valid = 1'b0;
    rd_sel = 1'b0; #1;
    check("spurious_dv", rd_data, 32'h01234567);

    // key-word write invalidates the schedule, then cmd 1 is rejected
    wr(3'd2, 32'h8899aabb);
    check("kw_clears_kl", key_loaded, 0);
    dp0 = data_pulses;
    issue(2'd1);
    tick();
    check("nokey_err", {err, cmd_ready, data_pulses - dp0}, {1'b1, 1'b1, 32'd0});

    // reserved command sets err; cmd 0 accepted clears it
    issue(2'd3);
    check("cmd3_err", {err, cmd_ready}, 2'b11);
    issue(2'd0);
    check("cmd0_clr_err", err, 0);
    tick();
    finish_key();
    check("reload_kl", key_loaded, 1);

    // after reset a data command without key load fails
    do_reset();
    issue(2'd1);
    check("rst_nokey_err", {err, cmd_ready, core_data_rdy}, 3'b110);

    // watchdog on DATA_WAIT
    load_key(KEY);
    issue(2'd0);
    tick();
    finish_key();
    wr(3'd4, PT[63:32]);
    wr(3'd5, PT[31:0]);
    issue(2'd1);
    tick();
    for (int i = 1; i <= 16; i++) begin
      if (i == 1) begin
        wr_en = 1'b1; wr_addr = 3'd4; wr_data = 32'hffffffff;
      end else begin
        wr_en = 1'b0;
      end
      tick();
      if (i == 15) check("wd_pre", {err, cmd_ready}, 2'b00);
    end
    check("wd_abort", {err, cmd_ready, result_valid, key_loaded}, 4'b1101);
    check("wd_no_write", core_data_in, PT);

    // reset during DATA_WAIT
    issue(2'd2);
    tick();
    core_busy = 1'b1;
    nreset = 1'b0;
    tick();
    check("mid_rst", {result_valid, key_loaded, err, core_key_rdy, core_data_rdy, core_en_de, cmd_ready},
          7'b0000000);
    check("mid_rst_regs", {core_key_in, core_data_in, rd_data}, 0);
    core_busy = 1'b0; #1;
    check("mid_rst_ready", cmd_ready, 1);
    nreset = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
